// File: rtl/keypad_entry_buffer.sv
// Shift-in BCD time-entry register for a microwave keypad: collects digits,
// validates the preset on start, strobes the countdown load and locks out keys while cooking.
module keypad_entry_buffer #(
  parameter int NUM_DIGITS = 3,
  parameter int MAX_TENS   = 5
) (
  input  logic                    clk,
  input  logic                    clear,
  input  logic [3:0]              key_bcd,
  input  logic                    key_strobe,
  input  logic                    start_req,
  input  logic                    cancel_req,
  input  logic                    timer_done,
  output logic [4*NUM_DIGITS-1:0] entry_bcd,
  output logic [2:0]              digit_count,
  output logic                    load_pulse,
  output logic                    locked,
  output logic                    err
);

  localparam int W = 4 * NUM_DIGITS;

  typedef enum logic [1:0] {IDLE, ENTRY, LOCKED} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   entry_q, entry_d;
  logic [2:0]     count_q, count_d;
  logic           load_q, load_d;
  logic           locked_q, locked_d;
  logic           err_q, err_d;

  logic           key_valid;
  logic           tens_ok;
  logic [W-1:0]   shifted;

  assign key_valid = (key_bcd <= 4'd9);
  assign tens_ok   = (entry_q[7:4] <= 4'(MAX_TENS));
  assign shifted   = {entry_q[W-5:0], key_bcd};

  // Each branch chain follows the fixed priority: cancel, timer_done, start, key.
  always_comb begin
    state_d  = state_q;
    entry_d  = entry_q;
    count_d  = count_q;
    load_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (cancel_req || timer_done) begin
          state_d = IDLE;
        end else if (start_req) begin
          err_d = 1'b1;
        end else if (key_strobe) begin
          if (key_valid) begin
            entry_d = {{(W-4){1'b0}}, key_bcd};
            count_d = 3'd1;
            state_d = ENTRY;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ENTRY: begin
        if (cancel_req) begin
          entry_d = '0;
          count_d = 3'd0;
          state_d = IDLE;
        end else if (timer_done) begin
          state_d = ENTRY;
        end else if (start_req) begin
          if (tens_ok) begin
            load_d  = 1'b1;
            state_d = LOCKED;
          end else begin
            err_d = 1'b1;
          end
        end else if (key_strobe) begin
          if (!key_valid || count_q == 3'(NUM_DIGITS)) begin
            err_d = 1'b1;
          end else begin
            entry_d = shifted;
            count_d = count_q + 3'd1;
          end
        end
      end
      LOCKED: begin
        if (cancel_req || timer_done) begin
          entry_d = '0;
          count_d = 3'd0;
          state_d = IDLE;
        end
      end
      default: begin
        entry_d = '0;
        count_d = 3'd0;
        state_d = IDLE;
      end
    endcase
    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q  <= IDLE;
      entry_q  <= '0;
      count_q  <= 3'd0;
      load_q   <= 1'b0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      entry_q  <= entry_d;
      count_q  <= count_d;
      load_q   <= load_d;
      locked_q <= locked_d;
      err_q    <= err_d;
    end
  end

  assign entry_bcd   = entry_q;
  assign digit_count = count_q;
  assign load_pulse  = load_q;
  assign locked      = locked_q;
  assign err         = err_q;

endmodule

// File: tb/tb_keypad_entry_buffer.sv
// Directed self-checking bench for keypad_entry_buffer with hand-computed expectations.
module tb_keypad_entry_buffer;

  logic        clk = 1'b0;
  logic        clear = 1'b0;
  logic [3:0]  key_bcd = 4'd0;
  logic        key_strobe = 1'b0;
  logic        start_req = 1'b0;
  logic        cancel_req = 1'b0;
  logic        timer_done = 1'b0;
  logic [11:0] entry_bcd;
  logic [2:0]  digit_count;
  logic        load_pulse;
  logic        locked;
  logic        err;

  int checks = 0;
  int errors = 0;

  keypad_entry_buffer #(.NUM_DIGITS(3), .MAX_TENS(5)) dut (
    .clk         (clk),
    .clear       (clear),
    .key_bcd     (key_bcd),
    .key_strobe  (key_strobe),
    .start_req   (start_req),
    .cancel_req  (cancel_req),
    .timer_done  (timer_done),
    .entry_bcd   (entry_bcd),
    .digit_count (digit_count),
    .load_pulse  (load_pulse),
    .locked      (locked),
    .err         (err)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, let the edge take them, then return all strobes low.
  task automatic applyStimulus(input logic [3:0] key, input logic strobe, input logic start,
                               input logic cancel, input logic done, input logic clr);
    key_bcd    = key;
    key_strobe = strobe;
    start_req  = start;
    cancel_req = cancel;
    timer_done = done;
    clear      = clr;
    @(posedge clk);
    #1;
    key_strobe = 1'b0;
    start_req  = 1'b0;
    cancel_req = 1'b0;
    timer_done = 1'b0;
    clear      = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [11:0] exp_entry, input logic [2:0] exp_count,
                             input logic exp_load, input logic exp_locked, input logic exp_err);
    checks++;
    assert (entry_bcd === exp_entry) else begin
      errors++;
      $error("[TB] FAIL %s entry_bcd got %h expected %h", tag, entry_bcd, exp_entry);
    end
    checks++;
    assert (digit_count === exp_count) else begin
      errors++;
      $error("[TB] FAIL %s digit_count got %0d expected %0d", tag, digit_count, exp_count);
    end
    checks++;
    assert (load_pulse === exp_load) else begin
      errors++;
      $error("[TB] FAIL %s load_pulse got %b expected %b", tag, load_pulse, exp_load);
    end
    checks++;
    assert (locked === exp_locked) else begin
      errors++;
      $error("[TB] FAIL %s locked got %b expected %b", tag, locked, exp_locked);
    end
    checks++;
    assert (err === exp_err) else begin
      errors++;
      $error("[TB] FAIL %s err got %b expected %b", tag, err, exp_err);
    end
  endtask

  initial begin
    applyStimulus(4'd0, 0, 0, 0, 0, 1);
    checkOutput("reset", 12'h000, 3'd0, 0, 0, 0);

    // T1
    applyStimulus(4'd1, 1, 0, 0, 0, 0);
    checkOutput("t1_key1", 12'h001, 3'd1, 0, 0, 0);
    applyStimulus(4'd3, 1, 0, 0, 0, 0);
    checkOutput("t1_key3", 12'h013, 3'd2, 0, 0, 0);
    applyStimulus(4'd0, 1, 0, 0, 0, 0);
    checkOutput("t1_key0", 12'h130, 3'd3, 0, 0, 0);

    // T2
    applyStimulus(4'd7, 1, 0, 0, 0, 0);
    checkOutput("t2_full_key", 12'h130, 3'd3, 0, 0, 1);
    applyStimulus(4'd0, 0, 0, 0, 0, 0);
    checkOutput("t2_err_drop", 12'h130, 3'd3, 0, 0, 0);

    // T3
    applyStimulus(4'd0, 0, 1, 0, 0, 0);
    checkOutput("t3_start", 12'h130, 3'd3, 1, 1, 0);
    applyStimulus(4'd5, 1, 0, 0, 0, 0);
    checkOutput("t3_locked_key5a", 12'h130, 3'd3, 0, 1, 0);
    applyStimulus(4'd5, 1, 1, 0, 0, 0);
    checkOutput("t3_locked_key5b", 12'h130, 3'd3, 0, 1, 0);
    applyStimulus(4'd0, 0, 0, 0, 1, 0);
    checkOutput("t3_done", 12'h000, 3'd0, 0, 0, 0);

    // T4
    applyStimulus(4'd1, 1, 0, 0, 0, 0);
    applyStimulus(4'd7, 1, 0, 0, 0, 0);
    applyStimulus(4'd5, 1, 0, 0, 0, 0);
    checkOutput("t4_entry", 12'h175, 3'd3, 0, 0, 0);
    applyStimulus(4'd0, 0, 1, 0, 0, 0);
    checkOutput("t4_bad_tens", 12'h175, 3'd3, 0, 0, 1);
    applyStimulus(4'd0, 0, 0, 1, 0, 0);
    checkOutput("t4_cancel", 12'h000, 3'd0, 0, 0, 0);

    // T5
    applyStimulus(4'hB, 1, 0, 0, 0, 0);
    checkOutput("t5_bad_key_idle", 12'h000, 3'd0, 0, 0, 1);
    applyStimulus(4'd0, 0, 1, 0, 0, 0);
    checkOutput("t5_start_idle", 12'h000, 3'd0, 0, 0, 1);

    // T6
    applyStimulus(4'd2, 1, 0, 0, 0, 0);
    applyStimulus(4'd5, 1, 0, 0, 0, 0);
    checkOutput("t6_entry", 12'h025, 3'd2, 0, 0, 0);
    applyStimulus(4'd0, 0, 1, 0, 0, 1);
    checkOutput("t6_clear_start", 12'h000, 3'd0, 0, 0, 0);
    applyStimulus(4'd2, 1, 0, 0, 0, 0);
    checkOutput("t6_key2", 12'h002, 3'd1, 0, 0, 0);
    applyStimulus(4'd9, 1, 0, 1, 0, 0);
    checkOutput("t6_cancel_key", 12'h000, 3'd0, 0, 0, 0);

    // Invalid key in ENTRY, then the MAX_TENS boundary is accepted.
    applyStimulus(4'd9, 1, 0, 0, 0, 0);
    checkOutput("idle_key9", 12'h009, 3'd1, 0, 0, 0);
    applyStimulus(4'hA, 1, 0, 0, 0, 0);
    checkOutput("entry_bad_key", 12'h009, 3'd1, 0, 0, 1);
    applyStimulus(4'd5, 1, 0, 0, 0, 0);
    applyStimulus(4'd9, 1, 0, 0, 0, 0);
    checkOutput("tens5_entry", 12'h959, 3'd3, 0, 0, 0);
    applyStimulus(4'd0, 0, 1, 0, 0, 0);
    checkOutput("tens5_start", 12'h959, 3'd3, 1, 1, 0);
    applyStimulus(4'd0, 0, 0, 0, 0, 0);
    checkOutput("load_one_cycle", 12'h959, 3'd3, 0, 1, 0);

    // Clear while cooking returns straight to reset values.
    applyStimulus(4'd0, 0, 0, 0, 0, 1);
    checkOutput("clear_locked", 12'h000, 3'd0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
